// File: rtl/ram_1p_host_adapter.sv
// Host-side adapter for a synchronous single-port SRAM with one cycle read
// latency. Requests pass combinationally to the RAM port. Every access
// (read or write) produces one response, which is buffered in a small
// FIFO. A credit check stops the host when the FIFO cannot take another
// response, so read data is never dropped.
module ram_1p_host_adapter #(
   parameter int unsigned Width           = 32,
   parameter int unsigned Depth           = 2048,
   parameter int unsigned DataBitsPerMask = 8,
   parameter int unsigned RspDepth        = 2,
   localparam int unsigned Aw             = $clog2(Depth),
   localparam int unsigned BeW            = Width / DataBitsPerMask
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   // host request channel
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_write_i,
   input  logic [Aw-1:0]    req_addr_i,
   input  logic [Width-1:0] req_wdata_i,
   input  logic [BeW-1:0]   req_be_i,
   // host response channel
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic             rsp_write_o,
   output logic [Width-1:0] rsp_rdata_o,
   // RAM port
   output logic             ram_req_o,
   output logic             ram_write_o,
   output logic [Aw-1:0]    ram_addr_o,
   output logic [Width-1:0] ram_wdata_o,
   output logic [Width-1:0] ram_wmask_o,
   input  logic             ram_rvalid_i,
   input  logic [Width-1:0] ram_rdata_i,
   // sticky protocol error
   output logic             err_o
);

   localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
   localparam int unsigned CntW = $clog2(RspDepth + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(RspDepth - 1);
   localparam logic [CntW:0]   Credits = (CntW + 1)'(RspDepth);

   logic             accept;
   logic             push;
   logic             pop;
   logic             push_write;
   logic [Width-1:0] push_data;
   logic             rd_inflight;
   logic [CntW:0]    used_cnt;

   logic             inflight_q;
   logic             inflight_wr_q;
   logic             err_q;
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;

   // response storage; data only, so no reset is needed
   logic             fifo_write_q [RspDepth];
   logic [Width-1:0] fifo_data_q  [RspDepth];

   // circular pointer advance that also wraps for non-power-of-two depths
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   // ---------------- request path ----------------
   assign accept      = req_valid_i & req_ready_o;
   assign ram_req_o   = accept;
   assign ram_write_o = accept & req_write_i;
   assign ram_addr_o  = req_addr_i;
   assign ram_wdata_o = req_wdata_i;

   // expand each byte enable into a run of mask bits, all zero when idle
   for (genvar gi = 0; gi < BeW; gi++) begin : g_wmask
      assign ram_wmask_o[gi*DataBitsPerMask +: DataBitsPerMask] =
         {DataBitsPerMask{req_be_i[gi] & accept}};
   end

   // credit check: buffered + in-flight responses, minus the one leaving now
   always_comb begin
      used_cnt    = (CntW + 1)'(count_q) + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
      req_ready_o = (used_cnt < Credits);
   end

   // ---------------- response path ----------------
   assign push        = inflight_q;
   assign push_write  = inflight_wr_q;
   assign push_data   = inflight_wr_q ? '0 : ram_rdata_i;
   assign rd_inflight = inflight_q & ~inflight_wr_q;

   assign rsp_valid_o = (count_q != '0);
   assign pop         = rsp_valid_o & rsp_ready_i;
   assign rsp_write_o = fifo_write_q[rd_ptr_q];
   assign rsp_rdata_o = fifo_data_q[rd_ptr_q];
   assign err_o       = err_q;

   // remember whether the RAM owes us a response next cycle, and of what kind
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_q    <= 1'b0;
         inflight_wr_q <= 1'b0;
      end else begin
         inflight_q    <= accept;
         inflight_wr_q <= req_write_i;
      end
   end

   // rvalid must appear exactly in the cycle a read is in flight, never otherwise
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (ram_rvalid_i ^ rd_inflight) begin
         err_q <= 1'b1;
      end
   end

   // write the pushed response into the tail slot
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_write_q[wr_ptr_q] <= push_write;
         fifo_data_q[wr_ptr_q]  <= push_data;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keeps the count
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_1p_host_adapter.sv
// Bench for ram_1p_host_adapter: a behavioural single-port RAM with one
// cycle read latency sits on the RAM port; a host-level model (shadow
// memory plus a queue of expected responses) predicts every response.
module tb_ram_1p_host_adapter;

   localparam int Width    = 32;
   localparam int Depth    = 2048;
   localparam int DBPM     = 8;
   localparam int RspDepth = 2;
   localparam int Aw       = 11;
   localparam int BeW      = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid, req_ready, req_write;
   logic [Aw-1:0]    req_addr;
   logic [Width-1:0] req_wdata;
   logic [BeW-1:0]   req_be;
   logic             rsp_valid, rsp_ready, rsp_write;
   logic [Width-1:0] rsp_rdata;
   logic             ram_req, ram_write;
   logic [Aw-1:0]    ram_addr;
   logic [Width-1:0] ram_wdata, ram_wmask;
   logic             ram_rvalid = 1'b0;
   logic [Width-1:0] ram_rdata  = '0;
   logic             err;

   logic             inject   = 1'b0;
   logic             suppress = 1'b0;

   logic [Width-1:0] ram_mem [Depth] = '{default: '0};
   logic [Width-1:0] shadow  [Depth] = '{default: '0};

   typedef struct {
      logic        wr;
      logic [31:0] data;
   } rsp_t;
   rsp_t exp_q[$];

   typedef struct {
      logic        wr;
      logic [10:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_wmask;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs [7];

   int  checks = 0;
   int  errors = 0;
   int  n_pop  = 0;
   int  n;
   int  pop_base;
   bit  acc;
   bit  hold;

   always #5 clk = ~clk;

   ram_1p_host_adapter #(
      .Width(Width), .Depth(Depth), .DataBitsPerMask(DBPM), .RspDepth(RspDepth)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
      .rsp_rdata_o(rsp_rdata),
      .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask),
      .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata),
      .err_o(err)
   );

   // behavioural RAM: bit-masked writes, read data one cycle after request
   always @(posedge clk) begin
      ram_rvalid <= 1'b0;
      if (ram_req && !ram_write) begin
         ram_rdata <= ram_mem[ram_addr];
         if (!suppress) ram_rvalid <= 1'b1;
      end
      if (ram_req && ram_write)
         ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      if (inject) ram_rvalid <= 1'b1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one clock with the host-level model: pops compared in order, accepts recorded
   task automatic sb_step(output bit accepted);
      bit   p;
      int   outstanding;
      rsp_t e;
      @(negedge clk);
      outstanding = exp_q.size();
      p = rsp_valid & rsp_ready;
      accepted = req_valid & req_ready;
      check("ready_rule", req_ready, ((outstanding - int'(p)) < RspDepth));
      if (p) begin
         n_pop++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got response with none outstanding");
         end else begin
            e = exp_q.pop_front();
            $display("rsp: write=%0b rdata=%08h expect write=%0b rdata=%08h",
                     rsp_write, rsp_rdata, e.wr, e.data);
            check("rsp_write", rsp_write, e.wr);
            check("rsp_rdata", rsp_rdata, e.data);
         end
      end
      if (accepted) begin
         if (req_write) begin
            shadow[req_addr] = apply_be(shadow[req_addr], req_wdata, req_be);
            e.wr = 1'b1;
            e.data = '0;
         end else begin
            e.wr = 1'b0;
            e.data = shadow[req_addr];
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      bit a;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 12 && exp_q.size() > 0; k++) sb_step(a);
      check(name, exp_q.size(), 0);
   endtask

   // single isolated transaction with cycle-exact latency checks
   task automatic run_vec(input vec_t v, input int idx);
      req_valid = 1'b1;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_be    = v.be;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("vec_req_ready", req_ready, 1'b1);
      check("vec_ram_req", ram_req, 1'b1);
      check("vec_ram_write", ram_write, v.wr);
      check("vec_ram_addr", ram_addr, v.addr);
      if (v.wr) begin
         check("vec_ram_wmask", ram_wmask, v.exp_wmask);
         check("vec_ram_wdata", ram_wdata, v.wdata);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("vec_rsp_not_yet", rsp_valid, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      $display("vec %0d: write=%0b addr=%03h wdata=%08h be=%b -> rsp_write=%0b rdata=%08h",
               idx, v.wr, v.addr, v.wdata, v.be, rsp_write, rsp_rdata);
      check("vec_rsp_valid", rsp_valid, 1'b1);
      check("vec_rsp_write", rsp_write, v.wr);
      check("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("vec_rsp_gone", rsp_valid, 1'b0);
      check("vec_idle_wmask", ram_wmask, 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{1'b1, 11'h005, 32'hDEADBEEF, 4'b1111, 32'hFFFFFFFF, 32'h0};
      vecs[1] = '{1'b0, 11'h005, 32'h0,        4'b0000, 32'h0,        32'hDEADBEEF};
      vecs[2] = '{1'b1, 11'h010, 32'hAAAAAAAA, 4'b1111, 32'hFFFFFFFF, 32'h0};
      vecs[3] = '{1'b1, 11'h010, 32'h11223344, 4'b0101, 32'h00FF00FF, 32'h0};
      vecs[4] = '{1'b0, 11'h010, 32'h0,        4'b0000, 32'h0,        32'hAA22AA44};
      vecs[5] = '{1'b1, 11'h010, 32'hFFFFFFFF, 4'b0000, 32'h0,        32'h0};
      vecs[6] = '{1'b0, 11'h010, 32'h0,        4'b0000, 32'h0,        32'hAA22AA44};

      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", req_ready, 1'b1);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_err", err, 1'b0);
      check("reset_ram_req", ram_req, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // table-driven isolated transactions
      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], i);
         if (vecs[i].wr)
            shadow[vecs[i].addr] = apply_be(shadow[vecs[i].addr], vecs[i].wdata, vecs[i].be);
      end

      // back-to-back alternating write/read, one per cycle
      rsp_ready = 1'b1;
      pop_base = n_pop;
      for (int i = 0; i < 16; i++) begin
         req_valid = 1'b1;
         req_write = (i % 2 == 0);
         req_addr  = Aw'(i / 2);
         req_wdata = $urandom;
         req_be    = 4'hF;
         sb_step(acc);
         check("b2b_accept", acc, 1'b1);
      end
      drain("b2b_drained");
      check("b2b_rsp_count", n_pop - pop_base, 16);

      // backpressure: only two reads fit, the rest wait for the host
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      n = 0;
      for (int c = 0; c < 6; c++) begin
         req_addr = Aw'(n);
         sb_step(acc);
         if (c >= 2) check("bp_stalled", acc, 1'b0);
         if (acc) n++;
      end
      check("bp_accepted", n, 2);
      check("bp_rsp_held", rsp_valid, 1'b1);
      rsp_ready = 1'b1;
      for (int c = 0; c < 20 && n < 4; c++) begin
         req_addr = Aw'(n);
         sb_step(acc);
         if (acc) n++;
      end
      check("bp_all_accepted", n, 4);
      drain("bp_drained");

      // randomized traffic with random host backpressure
      hold = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!hold) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = Aw'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_be    = 4'($urandom_range(0, 15));
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         sb_step(acc);
         hold = req_valid && !acc;
      end
      drain("rand_drained");
      check("rand_no_err", err, 1'b0);

      // unexpected rvalid with nothing in flight
      inject = 1'b1;
      @(posedge clk);
      #1;
      inject = 1'b0;
      @(negedge clk);
      check("err_not_early", err, 1'b0);
      @(posedge clk);
      #1;
      check("err_set", err, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("err_sticky", err, 1'b1);

      // asynchronous reset with two write responses buffered
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 11'h020;
      req_wdata = 32'h12345678;
      req_be    = 4'hF;
      repeat (4) @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_pre_valid", rsp_valid, 1'b1);
      check("rst_pre_ready", req_ready, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_err", err, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();

      // read whose rvalid never arrives: error, but response still delivered
      suppress  = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 11'h003;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("norv_err_not_early", err, 1'b0);
      @(posedge clk);
      #1;
      suppress = 1'b0;
      check("norv_err_set", err, 1'b1);
      check("norv_rsp_valid", rsp_valid, 1'b1);
      check("norv_rsp_write", rsp_write, 1'b0);
      check("norv_rsp_rdata", rsp_rdata, shadow[3]);
      $display("norv: rsp_write=%0b rdata=%08h err=%0b", rsp_write, rsp_rdata, err);
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
